periph_bus_master: RTL and testbench
====================================

PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 Parameter: POLL_TIMEOUT, default 1000, maximum number of bus reads a POLL command performs before it reports failure; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are high at a rising edge.
REQ-006 cmd_op  input  2  operation: 0 READ, 1 WRITE, 2 RMW, 3 POLL.
REQ-007 cmd_addr  input  5  peripheral byte address.
REQ-008 cmd_data  input  32  write data for WRITE, insert value for RMW, compare value for POLL.
REQ-009 cmd_mask  input  32  bit mask for RMW and POLL; ignored for READ and WRITE.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when both rsp_valid and rsp_ready are high at a rising edge.
REQ-012 rsp_data  output  32  for READ: value read; for WRITE and RMW: value written; for POLL: last value read.
REQ-013 rsp_err  output  1  high only for a POLL that timed out.
REQ-014 A  output  5  peripheral bus address.
REQ-015 WD  output  32  peripheral bus write data.
REQ-016 WE  output  1  peripheral bus write strobe; the responder captures the write on the rising edge.
REQ-017 RD  input  32  peripheral bus read data; combinational from A, valid in the same cycle.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR, RESP; cmd_ready SHALL be high only in IDLE, so at most one command is outstanding.
REQ-019 On acceptance, cmd_op, cmd_addr, cmd_data and cmd_mask SHALL be registered; next state SHALL be WR for WRITE and RD for all other operations.
REQ-020 In RD, A SHALL equal the registered address, WE SHALL be 0, and RD SHALL be sampled into the read register at the end of the cycle.
REQ-021 From RD: READ SHALL go to RESP; RMW SHALL go to WR.
REQ-022 From RD, for POLL: if (RD & mask) == (data & mask), the block SHALL go to RESP with rsp_err=0.
REQ-023 Otherwise, if the read count equals POLL_TIMEOUT, the block SHALL go to RESP with rsp_err=1; otherwise the count SHALL increment and the block SHALL stay in RD.
REQ-024 In WR, WE SHALL be 1 for exactly one cycle with A equal to the registered address; the block SHALL then go to RESP.
REQ-025 WD in WR SHALL be: for WRITE, the registered data; for RMW, (read & ~mask) | (data & mask).
REQ-026 WE SHALL be 0 in every state other than WR.
REQ-027 In RESP, rsp_valid SHALL stay high with rsp_data and rsp_err stable until rsp_ready; on that handshake the block SHALL return to IDLE.
REQ-028 Latency from the acceptance edge to rsp_valid high SHALL be: READ 2 cycles, WRITE 2 cycles, RMW 3 cycles, POLL 1+n cycles where n is the number of reads performed (n <= POLL_TIMEOUT).
REQ-029 A new command SHALL NOT be accepted in the cycle the response is consumed; cmd_ready SHALL rise in the following cycle.
REQ-030 A SHALL hold the last registered address while in IDLE and RESP.
REQ-031 The poll counter SHALL be $clog2(POLL_TIMEOUT+1) bits wide, SHALL be cleared on acceptance, and SHALL NOT wrap.

Reset
REQ-032 While rst_n is low, state SHALL be IDLE and all outputs SHALL be 0: WE=0, A=0, WD=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0.
REQ-033 After rst_n is deasserted, cmd_ready SHALL be 1 in the first cycle.
REQ-034 Reset asserted mid-operation SHALL force WE low immediately; the operation SHALL be abandoned with no response and no partial write.

Structure
REQ-035 Op encodings and peripheral address constants (DIN 0, DOUT 4, TIMER0 8, TIMER1 12, PWM0 16, ADOUT 20, 7SEG 24) SHALL live in package periph_bus_pkg.
REQ-036 The block SHALL be a single module with no sub-module; datapath registers and the FSM SHALL share one clocked process plus one combinational output process.

Verification
REQ-037 READ addr 0 while the responder model drives RD=0x0000_A5A5 -> rsp_valid 2 cycles after acceptance, rsp_data=0x0000_A5A5, rsp_err=0, WE never high.
REQ-038 WRITE addr 4 data 0x000F_00FF -> exactly one WE cycle with A=4 and WD=0x000F_00FF; rsp_data=0x000F_00FF.
REQ-039 RMW addr 24, register=0x1234_5678, mask 0x0000_FF00, data 0x0000_AB00 -> WD=0x1234_AB78, rsp after 3 cycles.
REQ-040 POLL addr 8, mask 0xFFFF_FFFF, data 5, timer increments once per cycle from 0 -> rsp_err=0, rsp_data=5; then POLL_TIMEOUT=4 with data that never matches -> exactly 4 reads, rsp_err=1.
REQ-041 Hold rsp_ready low for 10 cycles -> rsp_data and rsp_err stable, cmd_ready=0 throughout.
REQ-042 Assert rst_n low during the WR cycle of an RMW -> WE falls immediately, no rsp_valid, and cmd_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus master: op codes, FSM states,
// the peripheral address map and the read-modify-write merge.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2,
        OP_POLL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_e;

    localparam logic [4:0] ADDR_DIN    = 5'd0;
    localparam logic [4:0] ADDR_DOUT   = 5'd4;
    localparam logic [4:0] ADDR_TIMER0 = 5'd8;
    localparam logic [4:0] ADDR_TIMER1 = 5'd12;
    localparam logic [4:0] ADDR_PWM0   = 5'd16;
    localparam logic [4:0] ADDR_ADOUT  = 5'd20;
    localparam logic [4:0] ADDR_7SEG   = 5'd24;

    function automatic logic [31:0] rmw_merge(input logic [31:0] cur,
                                              input logic [31:0] ins,
                                              input logic [31:0] mask);
        return (cur & ~mask) | (ins & mask);
    endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Single-outstanding command master for a simple peripheral bus:
// READ, WRITE, read-modify-write and bounded POLL with a valid/ready response.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [4:0]  A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD
);

    localparam int             CW  = $clog2(POLL_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO = CW'(POLL_TIMEOUT);

    state_e        state, state_nxt;
    op_e           op_q;
    logic [4:0]    addr_q;
    logic [31:0]   data_q, mask_q, rd_q, rsp_data_q;
    logic          rsp_err_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic          poll_hit, poll_to;
    logic [31:0]   wr_val;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        WE        = 1'b0;
        WD        = '0;
        cnt_inc   = cnt_q + CW'(1);
        poll_hit  = ((RD ^ data_q) & mask_q) == '0;
        // cnt_inc counts the read in progress, so exactly POLL_TIMEOUT reads occur
        poll_to   = cnt_inc == TMO;
        wr_val    = (op_q == OP_RMW) ? rmw_merge(rd_q, data_q, mask_q) : data_q;
        case (state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid)
                    state_nxt = (cmd_op == OP_WRITE) ? S_WR : S_RD;
            end
            S_RD: begin
                case (op_q)
                    OP_RMW:  state_nxt = S_WR;
                    OP_POLL: if (poll_hit || poll_to) state_nxt = S_RESP;
                    default: state_nxt = S_RESP;
                endcase
            end
            S_WR: begin
                WE        = 1'b1;
                WD        = wr_val;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q   <= op_e'(cmd_op);
                    addr_q <= cmd_addr;
                    data_q <= cmd_data;
                    mask_q <= cmd_mask;
                    cnt_q  <= '0;
                end
                S_RD: begin
                    rd_q       <= RD;
                    rsp_data_q <= RD;
                    rsp_err_q  <= (op_q == OP_POLL) && !poll_hit && poll_to;
                    if (op_q == OP_POLL && !poll_hit && !poll_to) cnt_q <= cnt_inc;
                end
                S_WR: begin
                    rsp_data_q <= wr_val;
                    rsp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign A        = addr_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Scoreboard bench: two masters (default timeout and timeout 4) share one
// command driver; responses are checked by a monitor against queued expectations.
module tb_periph_bus_master;
    import periph_bus_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t cur_exp;
    int n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0, done_cnt = 0, tgt = 0;
    int we_cnt = 0, we4_cnt = 0;
    logic [4:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    bit          seen = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;

    logic        sel4 = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b1, tmr_clr = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0, cmd_mask = '0;

    logic        cv0, cr0, rv0, re0, we0, cv4, cr4, rv4, re4, we4;
    logic [4:0]  a0, a4;
    logic [31:0] rd0, wd0, rdat0, rd4, wd4, rdat4;
    logic        m_valid, m_err, m_cready;
    logic [31:0] m_data;

    assign cv0      = cmd_valid & ~sel4;
    assign cv4      = cmd_valid & sel4;
    assign m_valid  = sel4 ? rv4 : rv0;
    assign m_err    = sel4 ? re4 : re0;
    assign m_data   = sel4 ? rdat4 : rdat0;
    assign m_cready = sel4 ? cr4 : cr0;
    assign rd4      = '0;

    periph_bus_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv0), .cmd_ready(cr0), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .rsp_valid(rv0),
        .rsp_ready(rsp_ready), .rsp_data(rdat0), .rsp_err(re0), .A(a0), .WD(wd0),
        .WE(we0), .RD(rd0)
    );

    periph_bus_master #(.POLL_TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv4), .cmd_ready(cr4), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .rsp_valid(rv4),
        .rsp_ready(rsp_ready), .rsp_data(rdat4), .rsp_err(re4), .A(a4), .WD(wd4),
        .WE(we4), .RD(rd4)
    );

    // Responder: DIN is a fixed input pattern, TIMER0 free-runs, the rest are RAM.
    logic [31:0] regs [8];
    logic [31:0] timer = '0;
    always_comb begin
        if (a0 == ADDR_DIN)         rd0 = 32'h0000_A5A5;
        else if (a0 == ADDR_TIMER0) rd0 = timer;
        else                        rd0 = regs[a0[4:2]];
    end
    always @(posedge clk) begin
        timer <= tmr_clr ? 32'd0 : timer + 32'd1;
        if (we0) regs[a0[4:2]] <= wd0;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    always @(negedge clk) begin
        if (we0) begin
            we_cnt++;
            last_wa = a0;
            last_wd = wd0;
        end
        if (we4) we4_cnt++;
    end

    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (m_valid) begin
            if (!seen) begin
                seen = 1'b1;
                hold_d = m_data;
                hold_e = m_err;
                if (exp_q.size() == 0) chk("unexpected_rsp", m_valid, 1'b0);
                else begin
                    cur_exp = exp_q[0];
                    chk("rsp_latency", cyc - acc_cyc + 1, cur_exp.lat);
                    chk("rsp_data", m_data, cur_exp.data);
                    chk("rsp_err", m_err, cur_exp.err);
                end
            end else begin
                chk("hold_data", m_data, hold_d);
                chk("hold_err", m_err, hold_e);
            end
            chk("busy_cmd_ready", m_cready, 1'b0);
            if (rsp_ready) begin
                seen = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                done_cnt++;
            end
        end
    end

    task automatic issue(input logic s4, input logic [1:0] op, input logic [4:0] addr,
                         input logic [31:0] data, input logic [31:0] mask, input bit push,
                         input logic [31:0] ed, input logic ee, input int el);
        int waited = 0;
        sel4 = s4;
        cmd_op = op;
        cmd_addr = addr;
        cmd_data = data;
        cmd_mask = mask;
        cmd_valid = 1'b1;
        if (push) exp_q.push_back('{ed, ee, el});
        tgt = done_cnt + 1;
        @(negedge clk);
        while (!m_cready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!m_cready) chk("cmd_accept", m_cready, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (done_cnt < tgt && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < tgt) chk("rsp_wait", done_cnt, tgt);
        #1;
    endtask

    initial begin
        int w0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cr0, 1'b0);
        chk("rst_rsp_valid", rv0, 1'b0);
        chk("rst_rsp_data", rdat0, 32'h0);
        chk("rst_rsp_err", re0, 1'b0);
        chk("rst_we", we0, 1'b0);
        chk("rst_a", a0, 5'd0);
        chk("rst_wd", wd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", cr0, 1'b1);
        @(posedge clk);
        #1;

        w0 = we_cnt;
        issue(0, OP_READ, ADDR_DIN, 32'h0, 32'h0, 1, 32'h0000_A5A5, 0, 2);
        wait_rsp();
        chk("read_no_we", we_cnt, w0);

        w0 = we_cnt;
        issue(0, OP_WRITE, ADDR_DOUT, 32'h000F_00FF, 32'h0, 1, 32'h000F_00FF, 0, 2);
        wait_rsp();
        chk("write_we_count", we_cnt, w0 + 1);
        chk("write_a", last_wa, ADDR_DOUT);
        chk("write_wd", last_wd, 32'h000F_00FF);

        issue(0, OP_WRITE, ADDR_ADOUT, 32'hDEAD_BEEF, 32'h0, 1, 32'hDEAD_BEEF, 0, 2);
        wait_rsp();
        issue(0, OP_WRITE, ADDR_7SEG, 32'h1234_5678, 32'h0, 1, 32'h1234_5678, 0, 2);
        wait_rsp();

        w0 = we_cnt;
        issue(0, OP_RMW, ADDR_7SEG, 32'h0000_AB00, 32'h0000_FF00, 1, 32'h1234_AB78, 0, 3);
        wait_rsp();
        chk("rmw_we_count", we_cnt, w0 + 1);
        chk("rmw_a", last_wa, ADDR_7SEG);
        chk("rmw_wd", last_wd, 32'h1234_AB78);

        issue(0, OP_READ, ADDR_7SEG, 32'h0, 32'h0, 1, 32'h1234_AB78, 0, 2);
        wait_rsp();
        issue(0, OP_READ, ADDR_ADOUT, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 0, 2);
        wait_rsp();

        // Timer is zero at the acceptance edge; it reads 5 on the sixth read.
        tmr_clr = 1'b1;
        issue(0, OP_POLL, ADDR_TIMER0, 32'd5, 32'hFFFF_FFFF, 1, 32'd5, 0, 7);
        tmr_clr = 1'b0;
        wait_rsp();

        // Never matches: four reads then error, so 1+4 cycles to response.
        issue(1, OP_POLL, ADDR_TIMER1, 32'd1, 32'd1, 1, 32'd0, 1, 5);
        wait_rsp();
        chk("poll_to_no_we", we4_cnt, 0);

        rsp_ready = 1'b0;
        issue(0, OP_READ, ADDR_DOUT, 32'h0, 32'h0, 1, 32'h000F_00FF, 0, 2);
        repeat (10) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp();

        issue(0, OP_WRITE, ADDR_PWM0, 32'h0000_0011, 32'h0, 1, 32'h0000_0011, 0, 2);
        wait_rsp();

        w0 = we_cnt;
        issue(0, OP_RMW, ADDR_PWM0, 32'h0000_00AA, 32'h0000_00FF, 0, 32'h0, 0, 0);
        n = 0;
        @(negedge clk);
        while (!we0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rmw_wr_reached", we0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", we0, 1'b0);
        chk("midrst_rsp_valid", rv0, 1'b0);
        chk("midrst_cmd_ready", cr0, 1'b0);
        chk("midrst_a", a0, 5'd0);
        chk("midrst_wd", wd0, 32'h0);
        chk("midrst_rsp_data", rdat0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_midrst", cr0, 1'b1);
        @(posedge clk);
        #1;
        issue(0, OP_READ, ADDR_PWM0, 32'h0, 32'h0, 1, 32'h0000_0011, 0, 2);
        wait_rsp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
